// File: rtl/fp_normalize_if.sv
// fp_normalize_if: operand-in / result-out handshake bundle for the
// normalize/round/pack stage of the floating-point adder.
// master = upstream producer + downstream consumer side (drives operands and
// out_ready); slave = the fp_normalize stage itself.
interface fp_normalize_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 24
);
    // Operand side
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic [EXP_W-1:0]        in_exp;
    logic [MANT_W:0]         in_mant;
    logic                    in_guard;
    logic                    in_sticky;

    // Result side
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+MANT_W-1:0] out_data;
    logic                    out_overflow;
    logic                    out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_guard, in_sticky,
        output out_ready,
        input  in_ready,
        input  out_valid, out_data, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_guard, in_sticky,
        input  out_ready,
        output in_ready,
        output out_valid, out_data, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp_normalize.sv
// fp_normalize: post-add normalize, round and pack stage of the FP adder.
// Stage 1 captures the raw sum and its leading-zero count; stage 2
// renormalizes, adjusts the exponent, detects overflow/underflow/zero and
// registers the packed IEEE-754 single.
// Optional macro FP_NORM_RNE_EN: round-to-nearest-even in stage 2 using
// in_guard/in_sticky. Without it the mantissa is truncated and the guard and
// sticky inputs are ignored.
module fp_normalize #(
    parameter int EXP_W  = 8,   // binary32 exponent width (fixed)
    parameter int MANT_W = 24   // mantissa width including implicit 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_normalize_if.slave bus
);

    localparam int               FRAC_W  = MANT_W - 1;
    localparam int               LZ_W    = $clog2(MANT_W + 1);
    localparam int               DATA_W  = 1 + EXP_W + FRAC_W;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W:0]   E_ONE   = 1;

    // Pipeline control
    logic              s1_valid;
    logic              s2_valid;
    logic              s1_advance;
    logic              s2_advance;
    logic              in_ready_int;

    // Stage 1 payload
    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [MANT_W:0]   s1_mant;
    logic [LZ_W-1:0]   s1_lz;
    logic [LZ_W-1:0]   lz_c;

    // Stage 2 datapath
    logic [EXP_W-1:0]  lz_ext;
    logic              shift_in;
    logic [MANT_W:0]   shifted;
    logic [MANT_W-1:0] m;
    logic [EXP_W:0]    e9;
    logic              c_normal;
    logic [DATA_W-1:0] c_data;
    logic              c_ovf;
    logic              c_unf;

    // Stage 2 registers
    logic [DATA_W-1:0] s2_data;
    logic              s2_ovf;
    logic              s2_unf;

`ifdef FP_NORM_RNE_EN
    logic              s1_guard;
    logic              s1_sticky;
    logic              round_bit;
    logic              sticky_bit;
    logic              rnd_inc;
    logic [MANT_W:0]   m_rnd;
    logic              unused_bits;
`else
    logic              unused_bits;
`endif

    // ------------------------------------------------------------------
    // Handshake: stage 2 frees up when empty or drained, stage 1 follows it.
    // in_ready depends only on pipeline state and out_ready.
    // ------------------------------------------------------------------
    assign s2_advance   = !s2_valid || bus.out_ready;
    assign s1_advance   = s2_advance;
    assign in_ready_int = !s1_valid || s1_advance;

    assign bus.in_ready      = in_ready_int;
    assign bus.out_valid     = s2_valid;
    assign bus.out_data      = s2_data;
    assign bus.out_overflow  = s2_ovf;
    assign bus.out_underflow = s2_unf;

    // Leading-zero count of the 24-bit mantissa body (MANT_W when all zero).
    always_comb begin
        // NOTE: the default assignment up front means every path writes
        // lz_c, so no latch is inferred.
        lz_c = LZ_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (bus.in_mant[i]) begin
                lz_c = LZ_W'(MANT_W - 1 - i);
            end
        end
    end

    // Stage 1 occupancy: refilled whenever it can accept.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_ready_int) begin
            s1_valid <= bus.in_valid;
        end
    end

    // Stage 1 payload capture on accept.
    always_ff @(posedge clk) begin
        // NOTE: payload flops carry no reset; s1_valid alone says whether
        // they hold anything meaningful.
        if (in_ready_int && bus.in_valid) begin
            s1_sign <= bus.in_sign;
            s1_exp  <= bus.in_exp;
            s1_mant <= bus.in_mant;
            s1_lz   <= lz_c;
`ifdef FP_NORM_RNE_EN
            s1_guard  <= bus.in_guard;
            s1_sticky <= bus.in_sticky;
`endif
        end
    end

    assign lz_ext = {{(EXP_W - LZ_W){1'b0}}, s1_lz};

`ifdef FP_NORM_RNE_EN
    // The guard bit becomes the new LSB on a left shift.
    assign shift_in    = s1_guard;
    assign unused_bits = shifted[0];
`else
    // Truncation: left shifts fill with zeros; guard/sticky not used.
    assign shift_in    = 1'b0;
    assign unused_bits = ^{bus.in_guard, bus.in_sticky, shifted[0], m[MANT_W-1]};
`endif

    assign shifted = {s1_mant[MANT_W-1:0], shift_in} << s1_lz;

    // Stage 2 combinational result: special cases, renormalize, round, pack.
    always_comb begin
        c_data   = '0;
        c_ovf    = 1'b0;
        c_unf    = 1'b0;
        c_normal = 1'b0;
        m        = '0;
        e9       = '0;
`ifdef FP_NORM_RNE_EN
        round_bit  = 1'b0;
        sticky_bit = 1'b0;
        rnd_inc    = 1'b0;
        m_rnd      = '0;
`endif
        if (s1_mant == '0) begin
            // Exact zero: sign forced positive.
            c_data = '0;
        end else if (s1_exp == EXP_MAX) begin
            c_data = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
            c_ovf  = 1'b1;
        end else if (s1_mant[MANT_W]) begin
            // Carry out of the adder: shift right by one, bump exponent.
            m        = s1_mant[MANT_W:1];
            e9       = {1'b0, s1_exp} + E_ONE;
            c_normal = 1'b1;
`ifdef FP_NORM_RNE_EN
            round_bit  = s1_mant[0];
            sticky_bit = s1_guard | s1_sticky;
`endif
        end else if (s1_exp > lz_ext) begin
            // Cancellation: shift left by lz, reduce exponent.
            m        = shifted[MANT_W:1];
            e9       = {1'b0, s1_exp} - {1'b0, lz_ext};
            c_normal = 1'b1;
`ifdef FP_NORM_RNE_EN
            round_bit  = (s1_lz == '0) ? s1_guard : 1'b0;
            sticky_bit = (s1_lz == '0) ? s1_sticky : 1'b0;
`endif
        end else begin
            // Exponent exhausted: flush to signed zero, no denormals.
            c_data = {s1_sign, {(EXP_W + FRAC_W){1'b0}}};
            c_unf  = 1'b1;
        end

        if (c_normal) begin
`ifdef FP_NORM_RNE_EN
            rnd_inc = round_bit && (sticky_bit || m[0]);
            m_rnd   = {1'b0, m} + {{MANT_W{1'b0}}, rnd_inc};
            if (m_rnd[MANT_W]) begin
                // Rounding carried past the MSB: renormalize once more.
                m  = m_rnd[MANT_W:1];
                e9 = e9 + E_ONE;
            end else begin
                m  = m_rnd[MANT_W-1:0];
            end
`endif
            if (e9 >= {1'b0, EXP_MAX}) begin
                c_data = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
                c_ovf  = 1'b1;
            end else begin
                c_data = {s1_sign, e9[EXP_W-1:0], m[FRAC_W-1:0]};
            end
        end
    end

    // Stage 2 registers: load on advance, hold while backpressured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_ovf   <= 1'b0;
            s2_unf   <= 1'b0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            s2_data  <= s1_valid ? c_data : '0;
            s2_ovf   <= s1_valid && c_ovf;
            s2_unf   <= s1_valid && c_unf;
        end
    end

endmodule

// File: tb/tb_fp_normalize.sv
// tb_fp_normalize: directed, table-driven bench for fp_normalize.
// Expected values are hand-computed for both the truncating build and the
// FP_NORM_RNE_EN build; the column matching the compile is used.
module tb_fp_normalize;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic        guard;
        logic        sticky;
        logic [31:0] data_t;   // truncating build
        logic        ovf_t;
        logic [31:0] data_r;   // round-to-nearest-even build
        logic        ovf_r;
        logic        unf;
    } vec_t;

    localparam int NVEC = 17;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t vecs [NVEC];

    fp_normalize_if bus ();

    fp_normalize dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic s, input logic [7:0] e,
                           input logic [24:0] mnt, input logic g, input logic st,
                           input logic [31:0] dt, input logic ot,
                           input logic [31:0] dr, input logic orr, input logic u);
        vecs[i].sign   = s;
        vecs[i].exp    = e;
        vecs[i].mant   = mnt;
        vecs[i].guard  = g;
        vecs[i].sticky = st;
        vecs[i].data_t = dt;
        vecs[i].ovf_t  = ot;
        vecs[i].data_r = dr;
        vecs[i].ovf_r  = orr;
        vecs[i].unf    = u;
    endtask

    function automatic logic [31:0] want_data(input int i);
`ifdef FP_NORM_RNE_EN
        return vecs[i].data_r;
`else
        return vecs[i].data_t;
`endif
    endfunction

    function automatic logic want_ovf(input int i);
`ifdef FP_NORM_RNE_EN
        return vecs[i].ovf_r;
`else
        return vecs[i].ovf_t;
`endif
    endfunction

    task automatic drive(input int i);
        bus.in_sign   = vecs[i].sign;
        bus.in_exp    = vecs[i].exp;
        bus.in_mant   = vecs[i].mant;
        bus.in_guard  = vecs[i].guard;
        bus.in_sticky = vecs[i].sticky;
    endtask

    // One vector with out_ready high: checks accept, 2-cycle latency, result.
    task automatic run_vec(input int i);
        int lat;
        bit seen;
        @(negedge clk);
        drive(i);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'd1);
        check($sformatf("v%0d latency", i), 32'(lat), 32'd2);
        check($sformatf("v%0d data", i), bus.out_data, want_data(i));
        check($sformatf("v%0d ovf", i), 32'(bus.out_overflow), 32'(want_ovf(i)));
        check($sformatf("v%0d unf", i), 32'(bus.out_underflow), 32'(vecs[i].unf));
    endtask

    initial begin
        int          bp_idx [3];
        int          accepted;
        int          got;
        int          first_cyc;
        int          last_cyc;
        int          stray;
        logic        rdy;
        logic [31:0] got_data [3];

        total = 0;
        bad   = 0;

        //        idx sign exp    mant          g     s     trunc         ovf   rne           ovf   unf
        set_vec(0,  1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 32'h40000000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        set_vec(1,  1'b0, 8'd130, 25'h0000001, 1'b0, 1'b0, 32'h35800000, 1'b0, 32'h35800000, 1'b0, 1'b0);
        set_vec(2,  1'b1, 8'd100, 25'h0000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        set_vec(3,  1'b0, 8'd254, 25'h1800000, 1'b0, 1'b0, 32'h7F800000, 1'b1, 32'h7F800000, 1'b1, 1'b0);
        set_vec(4,  1'b0, 8'd5,   25'h0000100, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1);
        set_vec(5,  1'b1, 8'd255, 25'h0800000, 1'b0, 1'b0, 32'hFF800000, 1'b1, 32'hFF800000, 1'b1, 1'b0);
        set_vec(6,  1'b1, 8'd127, 25'h0800000, 1'b0, 1'b0, 32'hBF800000, 1'b0, 32'hBF800000, 1'b0, 1'b0);
        set_vec(7,  1'b1, 8'd0,   25'h0800000, 1'b0, 1'b0, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b1);
        set_vec(8,  1'b0, 8'd1,   25'h0400000, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1);
        set_vec(9,  1'b0, 8'd2,   25'h0400000, 1'b0, 1'b0, 32'h00800000, 1'b0, 32'h00800000, 1'b0, 1'b0);
        set_vec(10, 1'b0, 8'd253, 25'h1FFFFFE, 1'b0, 1'b0, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 1'b0, 1'b0);
        set_vec(11, 1'b0, 8'd127, 25'h1000001, 1'b0, 1'b1, 32'h40000000, 1'b0, 32'h40000001, 1'b0, 1'b0);
        set_vec(12, 1'b0, 8'd127, 25'h1000001, 1'b0, 1'b0, 32'h40000000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        set_vec(13, 1'b0, 8'd127, 25'h0800001, 1'b1, 1'b0, 32'h3F800001, 1'b0, 32'h3F800002, 1'b0, 1'b0);
        set_vec(14, 1'b0, 8'd127, 25'h0FFFFFF, 1'b1, 1'b1, 32'h3FFFFFFF, 1'b0, 32'h40000000, 1'b0, 1'b0);
        set_vec(15, 1'b0, 8'd127, 25'h0400000, 1'b1, 1'b0, 32'h3F000000, 1'b0, 32'h3F000001, 1'b0, 1'b0);
        set_vec(16, 1'b0, 8'd254, 25'h0FFFFFF, 1'b1, 1'b1, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);

        // Reset
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data", bus.out_data, 32'h0);
        check("rst ovf", 32'(bus.out_overflow), 32'd0);
        check("rst unf", 32'(bus.out_underflow), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Backpressure: three back-to-back inputs with out_ready low
        bp_idx[0] = 0;
        bp_idx[1] = 1;
        bp_idx[2] = 6;
        accepted  = 0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            bus.in_valid = (accepted < 3);
            if (accepted < 3) drive(bp_idx[accepted]);
            #1 rdy = bus.in_ready;
            @(posedge clk);
            if (bus.in_valid && rdy) accepted++;
        end
        check("bp accepted", 32'(accepted), 32'd2);
        @(negedge clk);
        #1;
        check("bp in_ready low", 32'(bus.in_ready), 32'd0);
        check("bp out_valid", 32'(bus.out_valid), 32'd1);
        check("bp head data", bus.out_data, want_data(bp_idx[0]));
        @(negedge clk);
        #1;
        check("bp head hold", bus.out_data, want_data(bp_idx[0]));
        check("bp flags hold", 32'({bus.out_overflow, bus.out_underflow}), 32'd0);

        got       = 0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (c > 0) @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (accepted < 3);
            if (accepted < 3) drive(bp_idx[accepted]);
            #1;
            if (bus.out_valid) begin
                got_data[got] = bus.out_data;
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                got++;
            end
            rdy = bus.in_ready;
            @(posedge clk);
            if (bus.in_valid && rdy) accepted++;
        end
        bus.in_valid = 1'b0;
        check("bp drained count", 32'(got), 32'd3);
        check("bp one per cycle", 32'(last_cyc - first_cyc), 32'd2);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp order %0d", k), got_data[k], want_data(bp_idx[k]));
        end
        stray = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        check("bp no duplicate", 32'(stray), 32'd0);

        // Reset mid-stream with both stages full
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(3);
        @(posedge clk);
        @(negedge clk);
        drive(4);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mid full out_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        check("mid rst out_data", bus.out_data, 32'h0);
        check("mid rst ovf", 32'(bus.out_overflow), 32'd0);
        check("mid rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        check("mid rst no stale", 32'(stray), 32'd0);

        // Recovery after reset
        run_vec(11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
